// File: rtl/rr_arb4_sel.sv
// Four-channel round-robin arbiter that drives a 2-bit select with a registered valid.
// Each grant can be capped by a per-grant cycle budget.
module rr_arb4_sel #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned PW  = 2;

    // Compare value for the forced release; unused when the budget is disabled.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic          TO_EN   = (TIMEOUT != 0);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   sel_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            gv_next;
    logic            to_next;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;
    logic            found;

    // First requesting channel at or after ptr, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int i = 0; i < NCH; i++) begin
            idx = ptr + PW'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        ptr_next   = ptr;
        cnt_next   = cnt;
        gv_next    = 1'b0;
        to_next    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    sel_next   = pick;
                    cnt_next   = '0;
                    gv_next    = 1'b1;
                end
            end
            GRANT: begin
                cnt_next = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
                // A coincident done wins over the budget, so no timeout pulse then.
                if (done) begin
                    state_next = IDLE;
                    ptr_next   = sel + PW'(1);
                end else if (TO_EN && (cnt == TO_LAST)) begin
                    state_next = IDLE;
                    ptr_next   = sel + PW'(1);
                    to_next    = 1'b1;
                end else begin
                    gv_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            ptr         <= '0;
            cnt         <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            sel         <= sel_next;
            ptr         <= ptr_next;
            cnt         <= cnt_next;
            grant_valid <= gv_next;
            timeout     <= to_next;
        end
    end

    a_timeout_not_valid: assert property (@(posedge clk) disable iff (rst)
        timeout |-> !grant_valid);

    a_valid_tracks_state: assert property (@(posedge clk) disable iff (rst)
        grant_valid == (state == GRANT));

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Directed bench for rr_arb4_sel: a vector table on the default-budget instance,
// plus hand-written timeout sequences on a TIMEOUT=4 instance.
module tb_rr_arb4_sel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] sel;
    logic       grant_valid;
    logic       timeout;

    logic [3:0] req4 = 4'b0000;
    logic       done4 = 1'b0;
    logic [1:0] sel4;
    logic       grant_valid4;
    logic       timeout4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_arb4_sel u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .sel         (sel),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    rr_arb4_sel #(.TIMEOUT(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .req         (req4),
        .done        (done4),
        .sel         (sel4),
        .grant_valid (grant_valid4),
        .timeout     (timeout4)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [1:0] sel;
        logic       gv;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic d,
                                input logic [1:0] s, input logic g, input logic t);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.sel = s; v.gv = g; v.to = t;
        return v;
    endfunction

    // Model of the downstream 2-to-4 decoder stage.
    function automatic logic [3:0] dec2to4(input logic [1:0] s);
        case (s)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] one_hot;

        // reset and idle
        vecs.push_back(mk(1, 4'b0000, 0, 2'd0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 1, 2'd0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 2'd0, 0, 0));
        // all four requesting: 0,1,2,3,0 with an idle cycle between grants
        vecs.push_back(mk(0, 4'b1111, 0, 2'd0, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 2'd0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 0, 2'd1, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 0, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 2'd2, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 0, 2'd3, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 2'd3, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 0, 2'd0, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 2'd0, 0, 0));
        // sel holds in GRANT while req changes
        vecs.push_back(mk(0, 4'b0010, 0, 2'd1, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 2'd1, 1, 0));
        vecs.push_back(mk(0, 4'b1000, 0, 2'd1, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 2'd1, 0, 0));
        // done in IDLE ignored
        vecs.push_back(mk(0, 4'b0000, 1, 2'd1, 0, 0));
        // channel 2 granted and released, then 0101 -> 0, then 0100 -> 2
        vecs.push_back(mk(0, 4'b0100, 0, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 2'd2, 0, 0));
        vecs.push_back(mk(0, 4'b0101, 0, 2'd0, 1, 0));
        vecs.push_back(mk(0, 4'b0101, 1, 2'd0, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 0, 2'd2, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 2'd2, 0, 0));
        // reset mid-grant on channel 3 restarts at channel 0
        vecs.push_back(mk(0, 4'b1001, 0, 2'd3, 1, 0));
        vecs.push_back(mk(1, 4'b1001, 0, 2'd0, 0, 0));
        vecs.push_back(mk(0, 4'b1001, 0, 2'd0, 1, 0));
        vecs.push_back(mk(0, 4'b1001, 1, 2'd0, 0, 0));
        vecs.push_back(mk(0, 4'b1001, 0, 2'd3, 1, 0));

        foreach (vecs[k]) begin
            rst  = vecs[k].rst;
            req  = vecs[k].req;
            done = vecs[k].done;
            tick();
            check($sformatf("step%0d grant_valid", k), int'(grant_valid), int'(vecs[k].gv));
            check($sformatf("step%0d sel", k), int'(sel), int'(vecs[k].sel));
            check($sformatf("step%0d timeout", k), int'(timeout), int'(vecs[k].to));
            if (vecs[k].gv) begin
                one_hot = 4'b0001 << vecs[k].sel;
                check($sformatf("step%0d decoder", k), int'(dec2to4(sel)), int'(one_hot));
            end
        end

        // default budget of 15: the grant on channel 3 above runs to the forced release
        done = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            check($sformatf("to15 hold%0d grant_valid", c), int'(grant_valid), 1);
            check($sformatf("to15 hold%0d timeout", c), int'(timeout), 0);
        end
        tick();
        check("to15 release grant_valid", int'(grant_valid), 0);
        check("to15 release timeout", int'(timeout), 1);
        check("to15 release sel", int'(sel), 3);
        req = 4'b0000;
        tick();
        check("to15 pulse end timeout", int'(timeout), 0);
        check("to15 idle grant_valid", int'(grant_valid), 0);

        // TIMEOUT=4: exactly four grant cycles, one timeout pulse, re-grant after idle
        req4 = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("to4 hold%0d grant_valid", c), int'(grant_valid4), 1);
            check($sformatf("to4 hold%0d sel", c), int'(sel4), 1);
            check($sformatf("to4 hold%0d timeout", c), int'(timeout4), 0);
        end
        tick();
        check("to4 release grant_valid", int'(grant_valid4), 0);
        check("to4 release timeout", int'(timeout4), 1);
        tick();
        check("to4 regrant grant_valid", int'(grant_valid4), 1);
        check("to4 regrant sel", int'(sel4), 1);
        check("to4 regrant timeout", int'(timeout4), 0);

        // done coinciding with the budget edge is a normal release
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("to4 tie hold%0d grant_valid", c), int'(grant_valid4), 1);
        end
        done4 = 1'b1;
        tick();
        check("to4 tie grant_valid", int'(grant_valid4), 0);
        check("to4 tie timeout", int'(timeout4), 0);
        done4 = 1'b0;
        req4  = 4'b0000;
        tick();
        check("to4 tie after timeout", int'(timeout4), 0);
        check("to4 tie after grant_valid", int'(grant_valid4), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb4_sel.md
RR_ARB4_SEL -- requirements
Module: rr_arb4_sel

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum grant length in cycles (0 disables the timeout, legal range 0..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: per-channel request, bit i = channel i.
REQ-005 The block SHALL have port done, input, 1 bit: the granted channel releases its grant.
REQ-006 The block SHALL have port sel, output, 2 bits: the granted channel index, driving the select input of the 2-to-4 decoder stage.
REQ-007 The block SHALL have port grant_valid, output, 1 bit: sel is valid and a grant is active.
REQ-008 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is force-released.
REQ-009 All outputs SHALL be registered; there are no combinational input-to-output paths.

Function
REQ-010 The block SHALL have two states, IDLE and GRANT, and a 2-bit round-robin pointer ptr.
REQ-011 In IDLE, when req != 0 at a rising edge, the next state SHALL be GRANT with grant_valid=1 after that edge (1-cycle latency).
REQ-012 In IDLE, sel SHALL load the first set bit of req, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with grant_valid=0 and sel unchanged.
REQ-014 In GRANT, sel SHALL hold constant regardless of req changes, including the granted channel's req falling.
REQ-015 In GRANT, done=1 at a rising edge SHALL cause the next state IDLE, grant_valid=0, and ptr=sel+1 (mod 4, 3 wraps to 0).
REQ-016 A grant counter SHALL clear on entry to GRANT and increment each cycle in GRANT, saturating at 255.
REQ-017 If TIMEOUT != 0, the counter reaches TIMEOUT-1, and done=0, the next edge SHALL give IDLE, grant_valid=0, ptr=sel+1 and timeout=1 for exactly one cycle.
REQ-018 If done=1 and the timeout condition hold on the same edge, the block SHALL treat it as a normal release with timeout=0.
REQ-019 done in IDLE SHALL be ignored.
REQ-020 After every release the block SHALL spend at least one cycle in IDLE, so there are no back-to-back grants.
REQ-021 A single persistent requester SHALL be re-granted after each release; with all four requesting, the order is 0,1,2,3,0.

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE, sel=00, grant_valid=0, timeout=0, ptr=0 and counter=0, overriding req and done.
REQ-023 rst asserted during GRANT SHALL abort the grant, with grant_valid=0 after that edge; arbitration restarts at channel 0.
REQ-024 The first arbitration after rst deasserts SHALL take one IDLE cycle, per REQ-011.

Verification
REQ-025 rst=1 for 2 cycles, then req=0000 -> sel=00, grant_valid=0, timeout=0 every cycle.
REQ-026 req=1111 held, done pulsed 1 cycle whenever grant_valid=1 -> grants sel=0,1,2,3,0 in that order, each separated by one grant_valid=0 cycle.
REQ-027 After channel 2 is granted and released (ptr=3), req=0101 -> sel=0 is granted; then req=0100 -> sel=2 is granted.
REQ-028 TIMEOUT=4, req=0010, done=0 -> grant_valid=1 for exactly 4 cycles, timeout=1 for 1 cycle, then sel=1 is re-granted after the IDLE cycle.
REQ-029 rst pulsed mid-grant with sel=3 -> grant_valid=0 next cycle; with req=1001, the next grant is sel=0, not 3.
REQ-030 sel feeding the 2-to-4 decoder -> the decoder output equals 0001<<sel whenever grant_valid=1, checked for every grant in REQ-026.
